// File: rtl/rtc_seq_pkg.sv
// Shared types and constants for the RTC multiplexed-bus sequencer:
// FSM states, port offsets, STATUS bit positions and the pin-drive decode.
package rtc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_A_SET,
    ST_A_STB,
    ST_A_HOLD,
    ST_D_SET,
    ST_D_STB,
    ST_D_HOLD,
    ST_RECOVER
  } rtc_state_t;

  localparam logic [7:0] OFS_ADDR   = 8'd0;
  localparam logic [7:0] OFS_WDATA  = 8'd1;
  localparam logic [7:0] OFS_RDGO   = 8'd2;
  localparam logic [7:0] OFS_STATUS = 8'd0;
  localparam logic [7:0] OFS_RDATA  = 8'd1;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_OVERRUN = 1;

  typedef struct packed {
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       ad_n;
    logic       ad_oe;
    logic [7:0] ad;
  } bus_pins_t;

  localparam bus_pins_t PINS_IDLE = '{
    cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, ad_n: 1'b1, ad_oe: 1'b0, ad: 8'h00
  };

  // Pin levels for a given state; the bus is only driven in address phases
  // and in write data phases, so rd_n low never coincides with ad_oe high.
  function automatic bus_pins_t bus_drive(input rtc_state_t st,
                                          input logic       is_read,
                                          input logic [7:0] addr,
                                          input logic [7:0] wdata);
    bus_pins_t p;
    p = PINS_IDLE;
    case (st)
      ST_A_SET, ST_A_STB, ST_A_HOLD: begin
        p.ad_n  = 1'b0;
        p.ad_oe = 1'b1;
        p.ad    = addr;
        if (st == ST_A_STB) begin
          p.cs_n = 1'b0;
          p.wr_n = 1'b0;
        end
      end
      ST_D_SET, ST_D_STB, ST_D_HOLD: begin
        p.ad_n = 1'b1;
        if (!is_read) begin
          p.ad_oe = 1'b1;
          p.ad    = wdata;
        end
        if (st == ST_D_STB) begin
          p.cs_n = 1'b0;
          if (is_read) p.rd_n = 1'b0;
          else         p.wr_n = 1'b0;
        end
      end
      default: p = PINS_IDLE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter timing one bus phase; phase_done marks the last
// cycle of the phase. Saturates at zero so it never wraps inside a phase.
module rtc_phase_timer #(
  parameter int PHASE_CYCLES = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load,
  output logic phase_done
);

  localparam int CW = $clog2(PHASE_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(PHASE_CYCLES - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= LOAD_VAL;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign phase_done = (r_count == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// PicoBlaze port-mapped sequencer for the RTC multiplexed address/data bus.
// Optional completion interrupt enabled by defining RTC_SEQ_IRQ_EN.
module rtc_bus_sequencer #(
  parameter int         PHASE_CYCLES = 10,
  parameter logic [7:0] PORT_BASE    = 8'h10
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  input  logic       read_strobe,
  output logic [7:0] in_port_o,
  output logic       busy_o,
  output logic       cs_n_o,
  output logic       rd_n_o,
  output logic       wr_n_o,
  output logic       ad_n_o,
  output logic [7:0] ad_o,
  output logic       ad_oe_o,
  input  logic [7:0] ad_i
`ifdef RTC_SEQ_IRQ_EN
  ,
  output logic       interrupt_o,
  input  logic       interrupt_ack_i
`endif
);

  import rtc_seq_pkg::*;

  localparam logic [7:0] P_ADDR   = PORT_BASE + OFS_ADDR;
  localparam logic [7:0] P_WDATA  = PORT_BASE + OFS_WDATA;
  localparam logic [7:0] P_RDGO   = PORT_BASE + OFS_RDGO;
  localparam logic [7:0] P_STATUS = PORT_BASE + OFS_STATUS;
  localparam logic [7:0] P_RDATA  = PORT_BASE + OFS_RDATA;

  rtc_state_t r_state, w_state_next;
  logic [7:0] r_addr, r_wdata, r_rdata;
  logic [7:0] r_wk_addr, r_wk_wdata;
  logic       r_wk_read;
  logic       r_overrun, r_busy;
  logic [7:0] r_in_port;
  bus_pins_t  r_pins;

  logic       w_phase_done, w_load;
  logic       w_wr_addr, w_wr_wdata, w_wr_rdgo, w_launch, w_idle, w_accept;
  logic [7:0] w_wk_addr_next, w_wk_wdata_next, w_rdata_next, w_status, w_in_port_next;
  logic       w_wk_read_next, w_overrun_next;
  bus_pins_t  w_pins_next;

  assign w_wr_addr  = write_strobe && (port_id == P_ADDR);
  assign w_wr_wdata = write_strobe && (port_id == P_WDATA);
  assign w_wr_rdgo  = write_strobe && (port_id == P_RDGO);
  assign w_launch   = w_wr_wdata || w_wr_rdgo;
  assign w_idle     = (r_state == ST_IDLE);
  assign w_accept   = w_launch && w_idle;

  rtc_phase_timer #(.PHASE_CYCLES(PHASE_CYCLES)) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load       (w_load),
    .phase_done (w_phase_done)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept)     w_state_next = ST_A_SET;
      ST_A_SET:   if (w_phase_done) w_state_next = ST_A_STB;
      ST_A_STB:   if (w_phase_done) w_state_next = ST_A_HOLD;
      ST_A_HOLD:  if (w_phase_done) w_state_next = ST_D_SET;
      ST_D_SET:   if (w_phase_done) w_state_next = ST_D_STB;
      ST_D_STB:   if (w_phase_done) w_state_next = ST_D_HOLD;
      ST_D_HOLD:  if (w_phase_done) w_state_next = ST_RECOVER;
      ST_RECOVER: if (w_phase_done) w_state_next = ST_IDLE;
      default:                      w_state_next = ST_IDLE;
    endcase
  end

  assign w_load = (w_state_next != r_state);

  // The launching write carries WDATA on out_port in the same cycle.
  always_comb begin
    w_wk_addr_next  = r_wk_addr;
    w_wk_wdata_next = r_wk_wdata;
    w_wk_read_next  = r_wk_read;
    if (w_accept) begin
      w_wk_addr_next  = r_addr;
      w_wk_wdata_next = w_wr_wdata ? out_port : r_wdata;
      w_wk_read_next  = w_wr_rdgo;
    end
  end

  // Pins are decoded from the next state and registered, so they are glitch-free.
  assign w_pins_next = bus_drive(w_state_next, w_wk_read_next, w_wk_addr_next, w_wk_wdata_next);

  assign w_rdata_next = (r_state == ST_D_STB && w_phase_done && r_wk_read) ? ad_i : r_rdata;

  always_comb begin
    w_overrun_next = r_overrun;
    if (w_launch && !w_idle)
      w_overrun_next = 1'b1;
    else if (read_strobe && port_id == P_STATUS)
      w_overrun_next = 1'b0;
  end

  always_comb begin
    w_status               = 8'h00;
    w_status[STAT_BUSY]    = r_busy;
    w_status[STAT_OVERRUN] = r_overrun;
    w_in_port_next         = 8'h00;
    if (port_id == P_STATUS)
      w_in_port_next = w_status;
    else if (port_id == P_RDATA)
      w_in_port_next = w_rdata_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_addr     <= 8'h00;
      r_wdata    <= 8'h00;
      r_rdata    <= 8'h00;
      r_wk_addr  <= 8'h00;
      r_wk_wdata <= 8'h00;
      r_wk_read  <= 1'b0;
      r_overrun  <= 1'b0;
      r_busy     <= 1'b0;
      r_in_port  <= 8'h00;
      r_pins     <= PINS_IDLE;
    end else begin
      r_state    <= w_state_next;
      if (w_wr_addr)  r_addr  <= out_port;
      if (w_wr_wdata) r_wdata <= out_port;
      r_rdata    <= w_rdata_next;
      r_wk_addr  <= w_wk_addr_next;
      r_wk_wdata <= w_wk_wdata_next;
      r_wk_read  <= w_wk_read_next;
      r_overrun  <= w_overrun_next;
      r_busy     <= (w_state_next != ST_IDLE);
      r_in_port  <= w_in_port_next;
      r_pins     <= w_pins_next;
    end
  end

  assign in_port_o = r_in_port;
  assign busy_o    = r_busy;
  assign cs_n_o    = r_pins.cs_n;
  assign rd_n_o    = r_pins.rd_n;
  assign wr_n_o    = r_pins.wr_n;
  assign ad_n_o    = r_pins.ad_n;
  assign ad_oe_o   = r_pins.ad_oe;
  assign ad_o      = r_pins.ad;

`ifdef RTC_SEQ_IRQ_EN
  logic r_irq;

  // Set on leaving RECOVER takes priority over a same-cycle acknowledge.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_irq <= 1'b0;
    else if (r_state == ST_RECOVER && w_phase_done)
      r_irq <= 1'b1;
    else if (interrupt_ack_i)
      r_irq <= 1'b0;
  end

  assign interrupt_o = r_irq;
`else
  // No interrupt: software polls STATUS.busy.
`endif

endmodule
